// File: rtl/avalon_pwm_pkg.sv
// Shared register map, CTRL bit layout and address-width helpers for the
// Avalon-MM PWM bank.
package avalon_pwm_pkg;

    localparam int REGS_PER_CH = 4;
    localparam int REG_PERIOD  = 0;
    localparam int REG_DUTY    = 1;
    localparam int REG_CTRL    = 2;
    localparam int REG_COUNT   = 3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_INV    = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_W      = 3;

    // IRQ_PEND sits directly after the last channel block.
    function automatic int irq_pend_addr(input int num_ch);
        return REGS_PER_CH * num_ch;
    endfunction

    function automatic int addr_width(input int num_ch);
        return $clog2(REGS_PER_CH * num_ch + 1);
    endfunction

endpackage

// File: rtl/avalon_pwm_channel.sv
// One PWM channel: double-buffered period/duty, free-running counter,
// registered compare output and a one-cycle wrap indication.
module avalon_pwm_channel
    import avalon_pwm_pkg::*;
#(
    parameter int CNT_W = 28
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              period_we_i,
    input  logic              duty_we_i,
    input  logic              ctrl_we_i,
    input  logic [CNT_W-1:0]  wdata_i,
    input  logic [CTRL_W-1:0] ctrl_wdata_i,
    output logic [CNT_W-1:0]  period_o,
    output logic [CNT_W-1:0]  duty_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              pwm_o,
    output logic              wrap_o
);

    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  duty_q, duty_d;
    logic [CNT_W-1:0]  per_a_q, per_a_d;
    logic [CNT_W-1:0]  duty_a_q, duty_a_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              pwm_q, pwm_d;
    logic              wrap;
    logic              en_rise;

    always_comb begin
        period_d = period_we_i ? wdata_i : period_q;
        duty_d   = duty_we_i ? wdata_i : duty_q;
        ctrl_d   = ctrl_we_i ? ctrl_wdata_i : ctrl_q;
        en_rise  = ctrl_d[CTRL_EN] & ~ctrl_q[CTRL_EN];
        // A period of 0 or 1 wraps every cycle; the <=1 test also keeps per_a-1 from underflowing.
        wrap = ctrl_q[CTRL_EN] &
               ((per_a_q <= CNT_W'(1)) | (cnt_q == per_a_q - CNT_W'(1)));

        per_a_d  = per_a_q;
        duty_a_d = duty_a_q;
        // Actives take the pre-write shadows, so a coinciding shadow write waits one more period.
        if (en_rise || wrap) begin
            per_a_d  = period_q;
            duty_a_d = duty_q;
        end

        if (!ctrl_d[CTRL_EN] || en_rise || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        pwm_d = ctrl_q[CTRL_INV] ^ (ctrl_q[CTRL_EN] & (cnt_q < duty_a_q));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            period_q <= '0;
            duty_q   <= '0;
            per_a_q  <= '0;
            duty_a_q <= '0;
            cnt_q    <= '0;
            ctrl_q   <= '0;
            pwm_q    <= 1'b0;
        end else begin
            period_q <= period_d;
            duty_q   <= duty_d;
            per_a_q  <= per_a_d;
            duty_a_q <= duty_a_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            pwm_q    <= pwm_d;
        end
    end

    assign period_o = period_q;
    assign duty_o   = duty_q;
    assign ctrl_o   = ctrl_q;
    assign count_o  = cnt_q;
    assign pwm_o    = pwm_q;
    assign wrap_o   = wrap;

endmodule

// File: rtl/avalon_pwm_bank.sv
// Avalon-MM slave with NUM_CH PWM channels: write decode, zero-wait read mux,
// sticky wrap-pending flags and the level interrupt.
module avalon_pwm_bank
    import avalon_pwm_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  CNT_W  = 28,
    localparam int AW     = addr_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AW-1:0]     address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq
);

    localparam int PEND_ADDR = irq_pend_addr(NUM_CH);

    logic              wr_en;
    logic [CNT_W-1:0]  period [NUM_CH];
    logic [CNT_W-1:0]  duty   [NUM_CH];
    logic [CNT_W-1:0]  count  [NUM_CH];
    logic [CTRL_W-1:0] ctrl   [NUM_CH];
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] irq_en;
    logic [NUM_CH-1:0] pend_q, pend_d;

    assign wr_en = chipselect & ~write_n;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic period_we, duty_we, ctrl_we;

            assign period_we = wr_en && (int'(address) == REGS_PER_CH * gi + REG_PERIOD);
            assign duty_we   = wr_en && (int'(address) == REGS_PER_CH * gi + REG_DUTY);
            assign ctrl_we   = wr_en && (int'(address) == REGS_PER_CH * gi + REG_CTRL);

            avalon_pwm_channel #(
                .CNT_W(CNT_W)
            ) u_channel (
                .clk_i       (clk),
                .rst_ni      (reset_n),
                .period_we_i (period_we),
                .duty_we_i   (duty_we),
                .ctrl_we_i   (ctrl_we),
                .wdata_i     (writedata[CNT_W-1:0]),
                .ctrl_wdata_i(writedata[CTRL_W-1:0]),
                .period_o    (period[gi]),
                .duty_o      (duty[gi]),
                .ctrl_o      (ctrl[gi]),
                .count_o     (count[gi]),
                .pwm_o       (pwm_out[gi]),
                .wrap_o      (wrap[gi])
            );

            assign irq_en[gi] = ctrl[gi][CTRL_IRQ_EN];
        end

        if (CNT_W < 32) begin : g_hi_bits
            logic unused_hi;
            assign unused_hi = ^writedata[31:CNT_W];
        end
    endgenerate

    // Set beats clear: a wrap in the same cycle as a write-1-to-clear keeps the flag.
    always_comb begin
        pend_d = pend_q;
        if (wr_en && (int'(address) == PEND_ADDR)) begin
            pend_d = pend_q & ~writedata[NUM_CH-1:0];
        end
        pend_d = pend_d | wrap;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign irq = |(pend_q & irq_en);

    always_comb begin
        readdata = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (int'(address) == REGS_PER_CH * ch + REG_PERIOD) readdata[CNT_W-1:0]  = period[ch];
            if (int'(address) == REGS_PER_CH * ch + REG_DUTY)   readdata[CNT_W-1:0]  = duty[ch];
            if (int'(address) == REGS_PER_CH * ch + REG_CTRL)   readdata[CTRL_W-1:0] = ctrl[ch];
            if (int'(address) == REGS_PER_CH * ch + REG_COUNT)  readdata[CNT_W-1:0]  = count[ch];
        end
        if (int'(address) == PEND_ADDR) readdata[NUM_CH-1:0] = pend_q;
    end

endmodule

// File: tb/tb_avalon_pwm_bank.sv
// Directed and randomized checks of avalon_pwm_bank against a cycle-level
// reference model built from the register-level behaviour.
`timescale 1ns/1ps
module tb_avalon_pwm_bank;

    localparam int NCH  = 8;
    localparam int CW   = 32;
    localparam int AW   = 6;
    localparam int PEND = 4 * NCH;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [AW-1:0]   address;
    logic            chipselect;
    logic            write_n;
    logic [31:0]     writedata;
    logic [31:0]     readdata;
    logic [NCH-1:0]  pwm_out;
    logic            irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0]    m_per [NCH];
    logic [31:0]    m_duty[NCH];
    logic [31:0]    m_pa  [NCH];
    logic [31:0]    m_da  [NCH];
    logic [31:0]    m_cnt [NCH];
    logic [2:0]     m_ctrl[NCH];
    logic [NCH-1:0] m_pwm;
    logic [NCH-1:0] m_pend;

    avalon_pwm_bank #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .pwm_out   (pwm_out),
        .irq       (irq)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_per[c] = '0; m_duty[c] = '0; m_pa[c] = '0; m_da[c] = '0;
            m_cnt[c] = '0; m_ctrl[c] = '0;
        end
        m_pwm  = '0;
        m_pend = '0;
    endtask

    function automatic logic [31:0] model_read(input int a);
        if (a < 4 * NCH) begin
            case (a % 4)
                0: return m_per[a / 4];
                1: return m_duty[a / 4];
                2: return {29'b0, m_ctrl[a / 4]};
                default: return m_cnt[a / 4];
            endcase
        end
        if (a == PEND) return {24'b0, m_pend};
        return '0;
    endfunction

    function automatic logic model_irq();
        logic r = 1'b0;
        for (int c = 0; c < NCH; c++) r = r | (m_pend[c] & m_ctrl[c][2]);
        return r;
    endfunction

    // Advance the model by one clock using the bus values present at the edge.
    task automatic model_step();
        logic [NCH-1:0] wrap_v, clr, pwm_n;
        logic [31:0]    per_n [NCH];
        logic [31:0]    duty_n[NCH];
        logic [2:0]     ctrl_n[NCH];
        logic           rise;
        int             a;
        if (!reset_n) begin
            model_reset();
            return;
        end
        wrap_v = '0;
        clr    = '0;
        for (int c = 0; c < NCH; c++) begin
            wrap_v[c] = m_ctrl[c][0] && (m_pa[c] <= 1 || m_cnt[c] == m_pa[c] - 1);
            pwm_n[c]  = m_ctrl[c][0] ? ((m_cnt[c] < m_da[c]) ^ m_ctrl[c][1]) : m_ctrl[c][1];
            per_n[c]  = m_per[c];
            duty_n[c] = m_duty[c];
            ctrl_n[c] = m_ctrl[c];
        end
        if (chipselect && !write_n) begin
            a = int'(address);
            if (a < 4 * NCH) begin
                case (a % 4)
                    0: per_n[a / 4]  = writedata;
                    1: duty_n[a / 4] = writedata;
                    2: ctrl_n[a / 4] = writedata[2:0];
                    default: ;
                endcase
            end else if (a == PEND) begin
                clr = writedata[NCH-1:0];
            end
        end
        for (int c = 0; c < NCH; c++) begin
            rise = ctrl_n[c][0] && !m_ctrl[c][0];
            if (rise || wrap_v[c]) begin
                m_pa[c] = m_per[c];
                m_da[c] = m_duty[c];
            end
            m_cnt[c]  = (!ctrl_n[c][0] || rise || wrap_v[c]) ? 32'd0 : m_cnt[c] + 32'd1;
            m_per[c]  = per_n[c];
            m_duty[c] = duty_n[c];
            m_ctrl[c] = ctrl_n[c];
        end
        m_pwm  = pwm_n;
        m_pend = (m_pend & ~clr) | wrap_v;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("pwm_out", 32'(pwm_out), 32'(m_pwm));
        check("irq", 32'(irq), 32'(model_irq()));
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = AW'(a);
        writedata  = d;
        tick();
        write_n    = 1'b1;
        chipselect = 1'b0;
    endtask

    task automatic check_rd(input int a);
        address = AW'(a);
        #1;
        check($sformatf("rd@%0d", a), readdata, model_read(a));
    endtask

    task automatic check_rd_exp(input int a, input logic [31:0] exp, input string tag);
        address = AW'(a);
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic wait_cnt(input int ch, input logic [31:0] v);
        for (int k = 0; k < 300 && m_cnt[ch] != v; k++) tick();
        check_rd_exp(4 * ch + 3, v, "wait_cnt");
    endtask

    // Sample one whole period (counts 0..period-1 of a 10-cycle period), optionally writing at step wstep.
    task automatic measure_high(input int ch, input int wstep, input int waddr,
                                input logic [31:0] wdata, output int highs);
        wait_cnt(ch, 0);
        highs = 0;
        for (int j = 0; j < 10; j++) begin
            if (j == wstep) wr(waddr, wdata);
            else tick();
            highs += int'(pwm_out[ch]);
        end
    endtask

    initial begin
        int h;
        int a;
        logic [31:0] d;

        reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        model_reset();
        #1 reset_n = 1'b0;
        #2;
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        for (int i = 0; i < 64; i++) check_rd_exp(i, 32'd0, "rst_rd");
        @(negedge clk);
        reset_n = 1'b1;

        // Basic PWM on ch0: PERIOD=10 DUTY=3
        wr(0, 10); wr(1, 3); wr(2, 1);
        for (int i = 0; i < 20; i++) begin
            check_rd_exp(3, 32'(i % 10), "count_seq");
            check("pwm_seq", 32'(pwm_out[0]), (i == 0) ? 32'd0 : 32'(((i - 1) % 10) < 3));
            tick();
        end

        // Double buffering
        measure_high(0, 5, 1, 7, h);  check("dbuf_cur", 32'(h), 32'd3);
        measure_high(0, -1, 0, 0, h); check("dbuf_next", 32'(h), 32'd7);
        measure_high(0, 9, 1, 2, h);  check("wrapwr_cur", 32'(h), 32'd7);
        measure_high(0, -1, 0, 0, h); check("wrapwr_defer", 32'(h), 32'd7);
        measure_high(0, -1, 0, 0, h); check("wrapwr_take", 32'(h), 32'd2);

        // Duty boundaries, normal and inverted
        wr(1, 0);  measure_high(0, -1, 0, 0, h); check("duty0", 32'(h), 32'd0);
        wr(1, 12); measure_high(0, -1, 0, 0, h); check("duty12", 32'(h), 32'd10);
        wr(2, 3);  measure_high(0, -1, 0, 0, h); check("duty12_inv", 32'(h), 32'd0);
        wr(1, 0);  measure_high(0, -1, 0, 0, h); measure_high(0, -1, 0, 0, h);
        check("duty0_inv", 32'(h), 32'd10);
        wr(2, 1);

        // PERIOD=1: counter stuck, pending set every cycle
        wr(0, 1);
        measure_high(0, -1, 0, 0, h); check("per1_duty0", 32'(h), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_rd_exp(3, 32'd0, "per1_count");
            tick();
        end
        wr(PEND, 1);
        check_rd_exp(PEND, 32'd1, "per1_pend");
        wr(1, 12); tick();
        measure_high(0, -1, 0, 0, h); check("per1_high", 32'(h), 32'd10);
        wr(2, 3); tick();
        measure_high(0, -1, 0, 0, h); check("per1_inv", 32'(h), 32'd0);
        wr(0, 10); wr(1, 3); wr(2, 1);

        // Interrupts on ch2
        wr(8, 5); wr(9, 2); wr(10, 5);
        check("irq_pre", 32'(irq), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("irq_rise", 32'(irq), 32'(k == 5));
        end
        wr(PEND, 4);
        check("irq_clr", 32'(irq), 32'd0);
        wait_cnt(2, 4);
        wr(PEND, 4);
        check_rd_exp(PEND, 32'(m_pend), "clr_vs_set");
        check("clr_vs_set_b2", 32'(readdata[2]), 32'd1);
        check("clr_vs_set_irq", 32'(irq), 32'd1);

        // Bus: RO and unmapped writes ignored
        wr(3, 32'hDEAD_BEEF);
        check_rd(3);
        check_rd_exp(0, 32'd10, "per_kept");
        wr(PEND + 1, 32'hFFFF_FFFF);
        check_rd_exp(PEND + 1, 32'd0, "unmapped_rd");
        check_rd_exp(63, 32'd0, "unmapped_top");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = int'($urandom_range(0, PEND + 1));
                d = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 12));
                if (a % 4 == 2 && a < PEND) d = $urandom;
                wr(a, d);
            end else begin
                tick();
            end
            check_rd(int'($urandom_range(0, 63)));
        end

        // Asynchronous reset mid-period
        wr(0, 10); wr(1, 3); wr(2, 5);
        repeat (4) tick();
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("mrst_pwm", 32'(pwm_out), 32'd0);
        check("mrst_irq", 32'(irq), 32'd0);
        for (int i = 0; i < 64; i++) check_rd_exp(i, 32'd0, "mrst_rd");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("post_rst_pwm", 32'(pwm_out), 32'd0);
            check_rd_exp(3, 32'd0, "post_rst_cnt");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
